// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: replays one rectangle command as a raster of X/{Y,pixel} bus writes.
// Optional colour-step trigger after each successful fill is enabled with VGA_RECT_COLOUR_STEP_EN.
module vga_rect_fill #(
  parameter int         HOR_RES      = 160,
  parameter int         VERT_RES     = 120,
  parameter logic [7:0] X_REG_ADDR   = 8'hB1,
  parameter logic [7:0] Y_REG_ADDR   = 8'hB0,
`ifdef VGA_RECT_COLOUR_STEP_EN
  parameter logic [7:0] COL_REG_ADDR = 8'hB2,
`endif
  parameter logic [7:0] IDLE_ADDR    = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] X0,
  input  logic [6:0] Y0,
  input  logic [7:0] X1,
  input  logic [6:0] Y1,
  input  logic       PIXEL,
  output logic       BUS_REQ,
  input  logic       BUS_GNT,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [7:0] X_MAX = 8'(HOR_RES - 1);
  localparam logic [6:0] Y_MAX = 7'(VERT_RES - 1);
  localparam logic [8:0] X_LIM = 9'(HOR_RES);
  localparam logic [7:0] Y_LIM = 8'(VERT_RES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_GNT,
    S_SET_X,
    S_SET_Y,
    S_ADVANCE,
`ifdef VGA_RECT_COLOUR_STEP_EN
    S_COL_HI,
    S_COL_LO,
`endif
    S_FINISH
  } state_t;

  state_t     state, state_nx;
  logic [7:0] x0_r, x1c, cx;
  logic [6:0] y0_r, y1c, cy;
  logic       pixel_r;
  logic       err_r;
  logic       last_px;
  logic       cmd_bad;
`ifdef VGA_RECT_COLOUR_STEP_EN
  logic       col_pend;  // raster finished, colour step still owed after a grant loss
`endif

  assign last_px = (cx == x1c) && (cy == y1c);
  assign cmd_bad = (x0_r > x1c) || (y0_r > y1c) ||
                   ({1'b0, x0_r} >= X_LIM) || ({1'b0, y0_r} >= Y_LIM);
  assign BUSY    = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  // NOTE: these are plain datapath registers, not a memory array, so they take the async reset too.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      x0_r     <= '0;
      y0_r     <= '0;
      x1c      <= '0;
      y1c      <= '0;
      pixel_r  <= 1'b0;
      err_r    <= 1'b0;
      cx       <= '0;
      cy       <= '0;
`ifdef VGA_RECT_COLOUR_STEP_EN
      col_pend <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (START) begin
          x0_r    <= X0;
          y0_r    <= Y0;
          x1c     <= (X1 > X_MAX) ? X_MAX : X1;
          y1c     <= (Y1 > Y_MAX) ? Y_MAX : Y1;
          pixel_r <= PIXEL;
        end
        S_CHECK: begin
          err_r    <= cmd_bad;
          cx       <= x0_r;
          cy       <= y0_r;
`ifdef VGA_RECT_COLOUR_STEP_EN
          col_pend <= 1'b0;
`endif
        end
        S_ADVANCE: begin
          // Clipping first guarantees cy stops at VERT_RES, so neither counter can wrap.
          if (cx < x1c) begin
            cx <= cx + 8'd1;
          end else begin
            cx <= x0_r;
            cy <= cy + 7'd1;
          end
`ifdef VGA_RECT_COLOUR_STEP_EN
          col_pend <= last_px;
`endif
        end
        default: ;
      endcase
    end
  end

  // Bus outputs follow BUS_GNT combinationally so a lost grant idles the bus in that same cycle.
  // NOTE: every output gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    state_nx     = state;
    BUS_REQ      = 1'b0;
    BUS_ADDR     = IDLE_ADDR;
    BUS_DATA_OUT = 8'h00;
    BUS_DATA_OE  = 1'b0;
    DONE         = 1'b0;
    ERR          = 1'b0;
    case (state)
      S_IDLE:  if (START) state_nx = S_CHECK;
      S_CHECK: state_nx = cmd_bad ? S_FINISH : S_WAIT_GNT;
      S_WAIT_GNT: begin
        BUS_REQ = 1'b1;
        if (BUS_GNT) begin
`ifdef VGA_RECT_COLOUR_STEP_EN
          state_nx = col_pend ? S_COL_HI : S_SET_X;
`else
          state_nx = S_SET_X;
`endif
        end
      end
      S_SET_X: begin
        BUS_REQ = 1'b1;
        if (BUS_GNT) begin
          BUS_ADDR     = X_REG_ADDR;
          BUS_DATA_OUT = cx;
          BUS_DATA_OE  = 1'b1;
          state_nx     = S_SET_Y;
        end else begin
          state_nx = S_WAIT_GNT;
        end
      end
      S_SET_Y: begin
        BUS_REQ = 1'b1;
        if (BUS_GNT) begin
          BUS_ADDR     = Y_REG_ADDR;
          BUS_DATA_OUT = {cy, pixel_r};
          BUS_DATA_OE  = 1'b1;
          state_nx     = S_ADVANCE;
        end else begin
          state_nx = S_WAIT_GNT;
        end
      end
      S_ADVANCE: begin
        // The pixel is already written, so the raster advances even if the grant drops here.
        BUS_REQ = 1'b1;
        if (last_px) begin
`ifdef VGA_RECT_COLOUR_STEP_EN
          state_nx = BUS_GNT ? S_COL_HI : S_WAIT_GNT;
`else
          state_nx = S_FINISH;
`endif
        end else begin
          state_nx = BUS_GNT ? S_SET_X : S_WAIT_GNT;
        end
      end
`ifdef VGA_RECT_COLOUR_STEP_EN
      S_COL_HI: begin
        BUS_REQ = 1'b1;
        if (BUS_GNT) begin
          BUS_ADDR     = COL_REG_ADDR;
          BUS_DATA_OUT = 8'h01;
          BUS_DATA_OE  = 1'b1;
          state_nx     = S_COL_LO;
        end else begin
          state_nx = S_WAIT_GNT;
        end
      end
      S_COL_LO: begin
        BUS_REQ = 1'b1;
        if (BUS_GNT) begin
          BUS_ADDR     = COL_REG_ADDR;
          BUS_DATA_OUT = 8'h00;
          BUS_DATA_OE  = 1'b1;
          state_nx     = S_FINISH;
        end else begin
          state_nx = S_WAIT_GNT;
        end
      end
`endif
      S_FINISH: begin
        DONE     = 1'b1;
        ERR      = err_r;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Bus-master pixel engine that sits directly upstream of the VGA frame-buffer bus slave.
- Accepts one rectangle command (corners plus 1-bit pixel value) and replays it as a raster sequence of bus writes:
  - address B1: X coordinate
  - address B0: {Y[6:0], pixel}
- Offloads the microprocessor from per-pixel writes. Arbitration with the CPU is through a request/grant pair.

Parameters:
- HOR_RES, 160, horizontal resolution; X clipped to HOR_RES-1.
- VERT_RES, 120, vertical resolution; Y clipped to VERT_RES-1.
- X_REG_ADDR, 8'hB1, bus address of the X coordinate register.
- Y_REG_ADDR, 8'hB0, bus address of the {Y,pixel} write register.
- COL_REG_ADDR, 8'hB2, bus address of the colour-step trigger.
- IDLE_ADDR, 8'hFF, address driven whenever the engine is not writing.

Ports:
- CLK  input  1  system clock (100 MHz)
- RESET  input  1  asynchronous reset, active-low
- START  input  1  one-cycle command strobe
- X0  input  8  left column
- Y0  input  7  top row
- X1  input  8  right column (inclusive)
- Y1  input  7  bottom row (inclusive)
- PIXEL  input  1  value written to every pixel of the rectangle
- BUS_REQ  output  1  request for the system bus
- BUS_GNT  input  1  bus granted to this engine
- BUS_ADDR  output  8  address driven onto the system bus
- BUS_DATA_OUT  output  8  data driven onto the system bus
- BUS_DATA_OE  output  1  tri-state enable for BUS_DATA_OUT (tri-state buffer lives at top level)
- BUSY  output  1  command in progress
- DONE  output  1  one-cycle completion pulse
- ERR  output  1  valid only with DONE; 1 = command rejected

Behaviour:
- Reset (RESET=0, takes effect immediately, asynchronous):
  - State IDLE.
  - BUS_REQ=0, BUS_ADDR=IDLE_ADDR, BUS_DATA_OUT=0, BUS_DATA_OE=0, BUSY=0, DONE=0, ERR=0.
  - An in-flight command is abandoned. Any bus cycle already sampled stays written; no further writes occur.
- States: IDLE, CHECK, WAIT_GNT, SET_X, SET_Y, ADVANCE, FINISH.
- IDLE:
  - On START=1, register the command and clip it: X1c=min(X1,HOR_RES-1), Y1c=min(Y1,VERT_RES-1).
  - BUSY=1 from the next cycle. Go to CHECK.
  - START while BUSY=1 is ignored.
- CHECK:
  - If X0>X1c, Y0>Y1c, X0>=HOR_RES or Y0>=VERT_RES: go to FINISH with ERR=1. No bus request and no bus writes are made.
  - Otherwise load cx=X0, cy=Y0 and go to WAIT_GNT.
- WAIT_GNT:
  - BUS_REQ=1. Outputs hold IDLE_ADDR with OE=0.
  - Move to SET_X on the first cycle BUS_GNT=1.
- SET_X (one cycle): BUS_ADDR=X_REG_ADDR, BUS_DATA_OUT=cx, OE=1.
- SET_Y (one cycle): BUS_ADDR=Y_REG_ADDR, BUS_DATA_OUT={cy,PIXEL_r}, OE=1.
  - Exactly one B0 cycle per pixel, so the slave's write enable is asserted for exactly one CLK edge.
- ADVANCE (one cycle): BUS_ADDR=IDLE_ADDR, OE=0. Raster update, X inner loop:
  - If cx<X1c: cx++.
  - Else cx=X0 and cy++.
  - If the pixel just written was (X1c,Y1c): go to FINISH; else go to SET_X.
- Grant loss: if BUS_GNT drops in SET_X, SET_Y or ADVANCE:
  - Engine drives IDLE_ADDR/OE=0 that cycle.
  - Returns to WAIT_GNT, then resumes at SET_X for the same pixel.
  - No pixel is skipped; a pixel may have its X rewritten.
- FINISH (one cycle):
  - BUS_REQ=0, DONE=1, ERR as decided. BUSY=0 on the next cycle, state IDLE.
- Timing:
  - Throughput 3 cycles per pixel under continuous grant.
  - For a w×h rectangle with grant held: DONE asserts 3 + 3·w·h cycles after the START edge.
- Widths:
  - Coordinates are compared unsigned.
  - cx is 8 bits and cy is 7 bits. No wrap is possible because X1c/Y1c are clipped first.
- BUS_REQ stays high from WAIT_GNT through the last ADVANCE.

Optional Feature:
- Macro: VGA_RECT_COLOUR_STEP_EN.
- Defined:
  - After the last pixel of a successful command, insert state COL_HI (BUS_ADDR=COL_REG_ADDR, data 8'h01), then COL_LO (COL_REG_ADDR, data 8'h00), before FINISH.
  - This produces exactly one rising edge on the slave's colour trigger, so the colour counter advances by one per fill.
  - Adds 2 cycles to latency. Grant loss in COL_HI/COL_LO restarts at COL_HI.
  - Not performed for ERR commands.
- Undefined: the states are absent; latency is as stated in Behaviour.

Test Plan:
- Reset, then START X0=10,Y0=5,X1=11,Y1=6,PIXEL=1, GNT tied 1 -> bus writes (B1,0A),(B0,0B),(B1,0B),(B0,0B),(B1,0A),(B0,0D),(B1,0B),(B0,0D); DONE at cycle 15, ERR=0.
- START X0=150,Y0=0,X1=200,Y1=0 -> clipped to X 150..159: exactly 10 B0 writes, last (B1,9F); DONE at cycle 33.
- START X0=20,X1=10 -> no BUS_REQ, no writes; DONE=1 with ERR=1 two cycles after START.
- Drop BUS_GNT for 4 cycles after the first SET_Y of a 3×1 fill -> outputs IDLE_ADDR/OE=0 while low; resume at pixel x+1; exactly 3 distinct B0 writes total.
- Assert RESET=0 mid-fill, asynchronous to CLK -> outputs reach reset values before the next edge; START after release runs a fresh command correctly.
- With VGA_RECT_COLOUR_STEP_EN, 1×1 fill -> (B1,x),(B0,..), then (B2,01),(B2,00); DONE at cycle 8. START during BUSY is ignored in all builds.
